// File: rtl/hier_path_pkg.sv
// Shared definitions for the hierarchy instance-path encoder/decoder pair.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hier_path_pkg;

  // Default tree shape, shared with the path encoder.
  localparam int HIER_DEPTH  = 10;
  localparam int HIER_FANOUT = 5;

  // Result code reported with every decoded frame.
  typedef enum logic [1:0] {
    PATH_OK        = 2'd0,
    PATH_ERR_DIGIT = 2'd1,
    PATH_ERR_SHORT = 2'd2,
    PATH_ERR_LONG  = 2'd3
  } path_err_e;

  // Decoder control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_HOLD    = 2'd3
  } path_state_e;

endpackage

// File: rtl/hier_path_decoder_if.sv
// Digit-serial path input stream plus decoded result output, both valid/ready.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the decoder, out_ready from the consumer.
interface hier_path_decoder_if #(
  parameter int DIGIT_W = 4,
  parameter int IDX_W   = 24
);
  logic               in_valid;
  logic               in_ready;
  logic [DIGIT_W-1:0] in_digit;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_index;
  logic [1:0]         out_err;

  // Path-stream source and result consumer side.
  modport master (
    output in_valid, in_digit, in_last, out_ready,
    input  in_ready, out_valid, out_index, out_err
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_digit, in_last, out_ready,
    output in_ready, out_valid, out_index, out_err
  );
endinterface

// File: rtl/hier_path_decoder.sv
// Decodes a framed root-first digit path into a flat mixed-radix leaf index plus error code.
// Latency: result valid the cycle after the final beat transfers; optional HIER_PATH_DECODER_ERR_CNT_EN adds err_cnt.
// Backpressure: in_ready drops while a result is held; result held stable until out_ready.
module hier_path_decoder
  import hier_path_pkg::*;
#(
  parameter int DEPTH   = HIER_DEPTH,
  parameter int FANOUT  = HIER_FANOUT,
  parameter int DIGIT_W = 4,
  parameter int IDX_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  hier_path_decoder_if.slave bus
`ifdef HIER_PATH_DECODER_ERR_CNT_EN
  ,
  output logic [15:0]        err_cnt
`endif
);

  // Counter only needs to reach DEPTH; it is never advanced past that.
  localparam int CNT_W = $clog2(DEPTH + 1);

  path_state_e      state_q, state_d;
  logic [IDX_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  path_err_e        err_q, err_d;
  logic [IDX_W-1:0] index_q, index_d;

  logic             in_ready;
  logic             out_valid;
  logic             beat_fire;
  logic             out_fire;
  logic [IDX_W-1:0] acc_base;
  logic [IDX_W-1:0] acc_next;
  logic             digit_bad;
  logic             at_last_level;
  logic             too_few;

  assign in_ready  = (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign beat_fire = bus.in_valid && in_ready;
  assign out_fire  = out_valid && bus.out_ready;

  // First beat of a frame always starts from an empty accumulator.
  assign acc_base      = (state_q == ST_IDLE) ? '0 : acc_q;
  assign acc_next      = acc_base * IDX_W'(FANOUT) + IDX_W'(bus.in_digit);
  assign digit_bad     = (32'(bus.in_digit) >= FANOUT);
  assign at_last_level = (cnt_q == CNT_W'(DEPTH - 1));
  assign too_few       = ((int'(cnt_q) + 1) < DEPTH);

  // Next-state, accumulator and error latching.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    index_d = index_q;
    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (beat_fire) begin
          acc_d = acc_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (digit_bad) begin
            err_d   = PATH_ERR_DIGIT;
            state_d = bus.in_last ? ST_HOLD : ST_DRAIN;
          end else if (at_last_level && !bus.in_last) begin
            err_d   = PATH_ERR_LONG;
            state_d = ST_DRAIN;
          end else if (bus.in_last && too_few) begin
            err_d   = PATH_ERR_SHORT;
            state_d = ST_HOLD;
          end else if (bus.in_last) begin
            err_d   = PATH_OK;
            index_d = acc_next;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_DRAIN: begin
        // Discard the remainder of a bad frame; the first error sticks.
        if (beat_fire && bus.in_last) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_fire) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = PATH_OK;
          index_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= PATH_OK;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      index_q <= index_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_index = index_q;
  assign bus.out_err   = out_valid ? err_q : PATH_OK;

`ifdef HIER_PATH_DECODER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating count of errored results taken by the consumer.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (out_fire && (err_q != PATH_OK) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_hier_path_decoder.sv
// Scoreboard bench for hier_path_decoder: reference model pushes expected results, monitor pops on handshake.
// Latency: checks result valid one cycle after the last beat.
// Backpressure: exercises held results under out_ready stalls and random out_ready.
module tb_hier_path_decoder;

  localparam int DEPTH   = 10;
  localparam int FANOUT  = 5;
  localparam int DIGIT_W = 4;
  localparam int IDX_W   = 24;

  typedef struct {
    longint idx;
    int     err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];
  bit   rand_rdy;
  bit   use_gaps;
  int   model_err_cnt;

  hier_path_decoder_if #(.DIGIT_W(DIGIT_W), .IDX_W(IDX_W)) bus ();

`ifdef HIER_PATH_DECODER_ERR_CNT_EN
  wire [15:0] err_cnt;
`endif

  hier_path_decoder #(
    .DEPTH(DEPTH), .FANOUT(FANOUT), .DIGIT_W(DIGIT_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef HIER_PATH_DECODER_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference: frame outcome straight from the path rules.
  function automatic exp_t model(input int d[$]);
    exp_t   e;
    int     n;
    int     lim;
    longint w;
    n = d.size();
    lim = (n < DEPTH) ? n : DEPTH;
    e.idx = 0;
    e.err = 0;
    for (int i = 0; i < lim; i++) begin
      if (d[i] >= FANOUT) begin
        e.err = 1;
        return e;
      end
    end
    if (n > DEPTH) e.err = 3;
    else if (n < DEPTH) e.err = 2;
    else begin
      for (int i = 0; i < n; i++) begin
        w = 1;
        for (int k = 0; k < DEPTH - 1 - i; k++) w = w * FANOUT;
        e.idx = e.idx + longint'(d[i]) * w;
      end
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after the transfer.
  task automatic send_beat(input int d, input bit last);
    int   guard;
    logic [31:0] dv;
    dv = d;
    bus.in_valid = 1'b1;
    bus.in_digit = dv[DIGIT_W-1:0];
    bus.in_last  = last;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) fail_now("in_ready_wait");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input int d[$], input bit push);
    if (push) exp_q.push_back(model(d));
    for (int i = 0; i < d.size(); i++) begin
      if (use_gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
      send_beat(d[i], i == d.size() - 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: compare on handshake, watch hold stability and in_ready recovery.
  initial begin
    bit             prev_valid;
    bit             prev_hs;
    logic [IDX_W-1:0] prev_idx;
    logic [1:0]     prev_err;
    exp_t           e;
    prev_valid = 0;
    prev_hs = 0;
    prev_idx = '0;
    prev_err = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 0;
        prev_hs = 0;
      end else begin
        if (prev_hs) chk("in_ready_after_hs", bus.in_ready, 1);
        if (bus.out_valid && prev_valid && !prev_hs) begin
          chk("hold_index_stable", bus.out_index, prev_idx);
          chk("hold_err_stable", bus.out_err, prev_err);
        end
        if (bus.out_valid) chk("in_ready_in_hold", bus.in_ready, 0);
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: got index %0d err %0d, expected none",
                     bus.out_index, bus.out_err);
          end else begin
            e = exp_q.pop_front();
            chk("out_err", bus.out_err, e.err);
            chk("out_index", bus.out_index, e.idx);
            if (e.err != 0 && model_err_cnt != 65535) model_err_cnt++;
          end
        end
        prev_valid = bus.out_valid;
        prev_hs    = bus.out_valid && bus.out_ready;
        prev_idx   = bus.out_index;
        prev_err   = bus.out_err;
      end
    end
  end

  // Random consumer backpressure, active only in the random phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    int d[$];
    int guard;
    n_checks = 0;
    n_pass = 0;
    rand_rdy = 0;
    use_gaps = 0;
    model_err_cnt = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_digit  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_index", bus.out_index, 0);
    chk("reset_out_err", bus.out_err, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;

    // Good frame, 1-cycle result latency.
    d = '{0, 0, 0, 0, 0, 0, 0, 0, 4, 3};
    send_frame(d, 1);
    chk("latency_out_valid", bus.out_valid, 1);
    chk("latency_index_23", bus.out_index, 23);
    idle(2);

    // Same frame held off by the consumer for 5 cycles.
    bus.out_ready = 1'b0;
    send_frame(d, 1);
    chk("stall_out_valid", bus.out_valid, 1);
    repeat (5) begin
      chk("stall_in_ready", bus.in_ready, 0);
      idle(1);
    end
    bus.out_ready = 1'b1;
    idle(1);
    chk("stall_released", bus.out_valid, 0);
    idle(1);

    // Illegal digit at beat 3, short frame, long frame.
    d = '{1, 2, 7, 0, 1, 2, 3, 4, 0, 1};
    send_frame(d, 1);
    idle(1);
    d = '{1, 1, 1, 1, 1, 1};
    send_frame(d, 1);
    idle(1);
    d = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
    send_frame(d, 1);
    idle(1);

    // Reset mid-frame: partial frame must vanish.
    d = '{1, 2, 3, 4, 0};
    send_frame(d, 0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midframe_rst_out_valid", bus.out_valid, 0);
    d = '{4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    send_frame(d, 1);
    chk("all_fours_index", bus.out_index, 9765624);
    idle(1);

    // Reset while a result is held: result is lost.
    bus.out_ready = 1'b0;
    d = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    send_frame(d, 0);
    chk("pre_rst_hold_valid", bus.out_valid, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("hold_rst_out_valid", bus.out_valid, 0);
    chk("hold_rst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    idle(2);

    // Randomized frames with gaps and random consumer stalls.
    rand_rdy = 1;
    use_gaps = 1;
    for (int f = 0; f < 60; f++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      if (kind == 7) len = $urandom_range(1, DEPTH - 1);
      else if (kind == 8) len = $urandom_range(DEPTH + 1, DEPTH + 3);
      else len = DEPTH;
      d = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 19) == 0) d.push_back($urandom_range(5, 15));
        else d.push_back($urandom_range(0, 4));
      end
      send_frame(d, 1);
    end
    rand_rdy = 0;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      idle(1);
      guard++;
    end
    if (exp_q.size() != 0) fail_now("drain_scoreboard");
    idle(2);

`ifdef HIER_PATH_DECODER_ERR_CNT_EN
    chk("err_cnt", err_cnt, model_err_cnt);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
